// File: rtl/conv_layer_sched.sv
// Layer sequencer for the 3x3 conv datapath: walks tiles, output channels and input groups,
// drives bank/weight/bias read addresses, and emits delayed output-write strobes.
module conv_layer_sched #(
  parameter int ADDR_W   = 14,
  parameter int W_ADDR_W = 7,
  parameter int B_ADDR_W = 5,
  parameter int DIM_W    = 7,
  parameter int LAT      = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [DIM_W-1:0]    i_cfg_tile_w_m1,
  input  logic [DIM_W-1:0]    i_cfg_tile_h_m1,
  input  logic [3:0]          i_cfg_in_grp_m1,
  input  logic [4:0]          i_cfg_out_ch_m1,
  input  logic [ADDR_W-1:0]   i_cfg_bank_stride,
  input  logic [ADDR_W-1:0]   i_cfg_grp_stride,
  input  logic [W_ADDR_W-1:0] i_cfg_w_base,
  input  logic [B_ADDR_W-1:0] i_cfg_b_base,
  input  logic                i_stall,
  output logic                o_busy,
  output logic                o_issue,
  output logic                o_first_grp,
  output logic [ADDR_W-1:0]   o_raddr_0,
  output logic [ADDR_W-1:0]   o_raddr_1,
  output logic [ADDR_W-1:0]   o_raddr_2,
  output logic [ADDR_W-1:0]   o_raddr_3,
  output logic [W_ADDR_W-1:0] o_raddr_weight,
  output logic [B_ADDR_W-1:0] o_raddr_bias,
  output logic                o_wr_en,
  output logic [ADDR_W-1:0]   o_waddr,
  output logic [4:0]          o_wr_ch,
  output logic                o_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]          r_state;
  logic [DIM_W-1:0]    r_tw_m1, r_th_m1, r_tx, r_ty;
  logic [3:0]          r_grp_m1, r_ig;
  logic [4:0]          r_och_m1, r_oc;
  logic [ADDR_W-1:0]   r_bank_stride, r_grp_stride;
  logic [W_ADDR_W-1:0] r_w_base, r_raddr_w;
  logic [B_ADDR_W-1:0] r_b_base, r_raddr_b;
  logic [ADDR_W-1:0]   r_raddr [4];
  logic [LAT-1:0]      r_dl_vld;
  logic [ADDR_W-1:0]   r_dl_tile [LAT];
  logic [4:0]          r_dl_ch [LAT];

  logic                w_issue, w_push, w_final, w_dl_empty;
  logic                w_ig_last, w_oc_last, w_tx_last, w_ty_last;
  logic [3:0]          w_ig_nxt;
  logic [4:0]          w_oc_nxt, w_grp_cnt;
  logic [DIM_W-1:0]    w_tx_nxt, w_ty_nxt;
  logic [DIM_W:0]      w_tw_cnt;
  logic [ADDR_W-1:0]   w_tile;
  logic [ADDR_W-1:0]   w_raddr_nxt [4];
  logic [W_ADDR_W-1:0] w_raddr_w_nxt;
  logic [B_ADDR_W-1:0] w_raddr_b_nxt;

  // Bank {r,c} holds the pixels whose row/col parity is r/c; the tile origin parity picks the offset.
  function automatic logic [ADDR_W-1:0] f_bank(input logic i_r, input logic i_c,
                                              input logic [DIM_W-1:0] i_ty, input logic [DIM_W-1:0] i_tx,
                                              input logic [3:0] i_ig,
                                              input logic [ADDR_W-1:0] i_bs, input logic [ADDR_W-1:0] i_gs);
    logic [DIM_W:0] v_row, v_col;
    v_row = ({1'b0, i_ty} + {{DIM_W{1'b0}}, i_r ^ i_ty[0]}) >> 1;
    v_col = ({1'b0, i_tx} + {{DIM_W{1'b0}}, i_c ^ i_tx[0]}) >> 1;
    return ADDR_W'(v_row) * i_bs + ADDR_W'(v_col) + ADDR_W'(i_ig) * i_gs;
  endfunction

  assign w_issue    = (r_state == S_RUN) & ~i_stall;
  assign w_ig_last  = (r_ig == r_grp_m1);
  assign w_oc_last  = (r_oc == r_och_m1);
  assign w_tx_last  = (r_tx == r_tw_m1);
  assign w_ty_last  = (r_ty == r_th_m1);
  assign w_final    = w_ig_last & w_oc_last & w_tx_last & w_ty_last;
  assign w_push     = w_issue & w_ig_last;
  assign w_dl_empty = ~|r_dl_vld;

  assign w_ig_nxt = w_ig_last ? 4'd0 : r_ig + 4'd1;
  assign w_oc_nxt = !w_ig_last ? r_oc : (w_oc_last ? 5'd0 : r_oc + 5'd1);
  assign w_tx_nxt = !(w_ig_last & w_oc_last) ? r_tx :
                    (w_tx_last ? '0 : r_tx + DIM_W'(1));
  assign w_ty_nxt = !(w_ig_last & w_oc_last & w_tx_last) ? r_ty :
                    (w_ty_last ? '0 : r_ty + DIM_W'(1));

  assign w_grp_cnt     = {1'b0, r_grp_m1} + 5'd1;
  assign w_tw_cnt      = {1'b0, r_tw_m1} + (DIM_W+1)'(1);
  assign w_tile        = ADDR_W'(r_ty) * ADDR_W'(w_tw_cnt) + ADDR_W'(r_tx);
  assign w_raddr_w_nxt = r_w_base + W_ADDR_W'(w_oc_nxt) * W_ADDR_W'(w_grp_cnt) + W_ADDR_W'(w_ig_nxt);
  assign w_raddr_b_nxt = r_b_base + B_ADDR_W'(w_oc_nxt);

  always_comb begin
    w_raddr_nxt = '{default: '0};
    for (int b = 0; b < 4; b++)
      w_raddr_nxt[b] = f_bank(b[1], b[0], w_ty_nxt, w_tx_nxt, w_ig_nxt, r_bank_stride, r_grp_stride);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_tw_m1       <= '0;
      r_th_m1       <= '0;
      r_grp_m1      <= '0;
      r_och_m1      <= '0;
      r_bank_stride <= '0;
      r_grp_stride  <= '0;
      r_w_base      <= '0;
      r_b_base      <= '0;
      r_ig          <= '0;
      r_oc          <= '0;
      r_tx          <= '0;
      r_ty          <= '0;
      r_raddr       <= '{default: '0};
      r_raddr_w     <= '0;
      r_raddr_b     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_tw_m1       <= i_cfg_tile_w_m1;
          r_th_m1       <= i_cfg_tile_h_m1;
          r_grp_m1      <= i_cfg_in_grp_m1;
          r_och_m1      <= i_cfg_out_ch_m1;
          r_bank_stride <= i_cfg_bank_stride;
          r_grp_stride  <= i_cfg_grp_stride;
          r_w_base      <= i_cfg_w_base;
          r_b_base      <= i_cfg_b_base;
          r_ig          <= '0;
          r_oc          <= '0;
          r_tx          <= '0;
          r_ty          <= '0;
          // Step (0,0,0,0) addresses reduce to zero bank offsets and the raw bases.
          r_raddr       <= '{default: '0};
          r_raddr_w     <= i_cfg_w_base;
          r_raddr_b     <= i_cfg_b_base;
          r_state       <= S_RUN;
        end
        S_RUN: if (w_issue) begin
          r_ig      <= w_ig_nxt;
          r_oc      <= w_oc_nxt;
          r_tx      <= w_tx_nxt;
          r_ty      <= w_ty_nxt;
          r_raddr   <= w_raddr_nxt;
          r_raddr_w <= w_raddr_w_nxt;
          r_raddr_b <= w_raddr_b_nxt;
          if (w_final) r_state <= S_DRAIN;
        end
        S_DRAIN: if (w_dl_empty) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data stages load only behind a valid, so the last stage holds waddr/wr_ch between writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dl_vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_dl_tile[i] <= '0;
        r_dl_ch[i]   <= '0;
      end
    end else begin
      r_dl_vld[0] <= w_push;
      if (w_push) begin
        r_dl_tile[0] <= w_tile;
        r_dl_ch[0]   <= r_oc;
      end
      for (int i = 1; i < LAT; i++) begin
        r_dl_vld[i] <= r_dl_vld[i-1];
        if (r_dl_vld[i-1]) begin
          r_dl_tile[i] <= r_dl_tile[i-1];
          r_dl_ch[i]   <= r_dl_ch[i-1];
        end
      end
    end
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_issue        = w_issue;
  assign o_first_grp    = w_issue & (r_ig == 4'd0);
  assign o_raddr_0      = r_raddr[0];
  assign o_raddr_1      = r_raddr[1];
  assign o_raddr_2      = r_raddr[2];
  assign o_raddr_3      = r_raddr[3];
  assign o_raddr_weight = r_raddr_w;
  assign o_raddr_bias   = r_raddr_b;
  assign o_wr_en        = r_dl_vld[LAT-1];
  assign o_waddr        = r_dl_tile[LAT-1];
  assign o_wr_ch        = r_dl_ch[LAT-1];
  assign o_done         = (r_state == S_DRAIN) & w_dl_empty;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Scoreboard bench for conv_layer_sched: directed layers with hand-computed address tables.
module tb_conv_layer_sched;
  localparam int LAT = 3;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_stall;
  logic [6:0]  i_cfg_tile_w_m1, i_cfg_tile_h_m1;
  logic [3:0]  i_cfg_in_grp_m1;
  logic [4:0]  i_cfg_out_ch_m1;
  logic [13:0] i_cfg_bank_stride, i_cfg_grp_stride;
  logic [6:0]  i_cfg_w_base;
  logic [4:0]  i_cfg_b_base;
  logic        o_busy, o_issue, o_first_grp, o_wr_en, o_done;
  logic [13:0] o_raddr_0, o_raddr_1, o_raddr_2, o_raddr_3, o_waddr;
  logic [6:0]  o_raddr_weight;
  logic [4:0]  o_raddr_bias, o_wr_ch;

  conv_layer_sched dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_cfg_tile_w_m1(i_cfg_tile_w_m1), .i_cfg_tile_h_m1(i_cfg_tile_h_m1),
    .i_cfg_in_grp_m1(i_cfg_in_grp_m1), .i_cfg_out_ch_m1(i_cfg_out_ch_m1),
    .i_cfg_bank_stride(i_cfg_bank_stride), .i_cfg_grp_stride(i_cfg_grp_stride),
    .i_cfg_w_base(i_cfg_w_base), .i_cfg_b_base(i_cfg_b_base), .i_stall(i_stall),
    .o_busy(o_busy), .o_issue(o_issue), .o_first_grp(o_first_grp),
    .o_raddr_0(o_raddr_0), .o_raddr_1(o_raddr_1), .o_raddr_2(o_raddr_2), .o_raddr_3(o_raddr_3),
    .o_raddr_weight(o_raddr_weight), .o_raddr_bias(o_raddr_bias),
    .o_wr_en(o_wr_en), .o_waddr(o_waddr), .o_wr_ch(o_wr_ch), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [13:0] a0, a1, a2, a3;
    logic [6:0]  w;
    logic [4:0]  b;
    logic        fg;
    logic        last;
  } iss_t;
  typedef struct packed {
    logic [13:0] addr;
    logic [4:0]  ch;
  } wr_t;

  iss_t q_iss[$];
  wr_t  q_wr[$];
  int   q_due[$];
  iss_t ei;
  wr_t  ew;
  int checks = 0, errors = 0;
  int cyc = 0, n_issue = 0, n_wr = 0, exp_done = 0, last_wr_cyc = -100;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor: pops expected issues/writes whenever the DUT presents them.
  always @(negedge i_clk) begin
    if (o_issue === 1'b1) begin
      n_issue++;
      if (q_iss.size() == 0) chk("spurious_issue", o_issue, 0);
      else begin
        ei = q_iss.pop_front();
        chk("raddr_0", o_raddr_0, ei.a0);
        chk("raddr_1", o_raddr_1, ei.a1);
        chk("raddr_2", o_raddr_2, ei.a2);
        chk("raddr_3", o_raddr_3, ei.a3);
        chk("raddr_weight", o_raddr_weight, ei.w);
        chk("raddr_bias", o_raddr_bias, ei.b);
        chk("first_grp", o_first_grp, ei.fg);
        if (ei.last) q_due.push_back(cyc + LAT);
      end
    end
    if (o_wr_en === 1'b1) begin
      n_wr++;
      last_wr_cyc = cyc;
      if (q_wr.size() == 0) chk("spurious_wr", o_wr_en, 0);
      else begin
        ew = q_wr.pop_front();
        chk("waddr", o_waddr, ew.addr);
        chk("wr_ch", o_wr_ch, ew.ch);
      end
      if (q_due.size() != 0) chk("wr_latency_cycle", cyc, q_due.pop_front());
    end
    if (o_done === 1'b1) begin
      if (exp_done == 0) chk("spurious_done", o_done, 0);
      else begin
        exp_done--;
        chk("done_after_wr_cycle", cyc, last_wr_cyc + 1);
      end
    end
  end

  task automatic set_cfg(input int tw, input int th, input int g, input int oc,
                         input int bs, input int gs, input int wb, input int bb);
    i_cfg_tile_w_m1   = 7'(tw);
    i_cfg_tile_h_m1   = 7'(th);
    i_cfg_in_grp_m1   = 4'(g);
    i_cfg_out_ch_m1   = 5'(oc);
    i_cfg_bank_stride = 14'(bs);
    i_cfg_grp_stride  = 14'(gs);
    i_cfg_w_base      = 7'(wb);
    i_cfg_b_base      = 5'(bb);
  endtask

  task automatic exp_iss(input int a0, input int a1, input int a2, input int a3,
                         input int w, input int b, input bit fg, input bit last);
    iss_t e;
    e.a0 = 14'(a0); e.a1 = 14'(a1); e.a2 = 14'(a2); e.a3 = 14'(a3);
    e.w = 7'(w); e.b = 5'(b); e.fg = fg; e.last = last;
    q_iss.push_back(e);
  endtask

  task automatic exp_wr(input int addr, input int ch);
    wr_t e;
    e.addr = 14'(addr); e.ch = 5'(ch);
    q_wr.push_back(e);
  endtask

  // 2x2 tiles, 2 groups, 2 out channels; bank stride 8, group stride 100, w_base 10, b_base 3.
  // Per-tile bank offsets {raddr_0..3} worked out by hand from the parity interleave.
  task automatic push_loop();
    int tbase [4][4];
    tbase = '{'{0, 0, 0, 0}, '{1, 0, 1, 0}, '{8, 8, 0, 0}, '{9, 8, 1, 0}};
    for (int t = 0; t < 4; t++)
      for (int oc = 0; oc < 2; oc++) begin
        for (int ig = 0; ig < 2; ig++)
          exp_iss(tbase[t][0] + ig*100, tbase[t][1] + ig*100, tbase[t][2] + ig*100,
                  tbase[t][3] + ig*100, 10 + oc*2 + ig, 3 + oc, ig == 0, ig == 1);
        exp_wr(t, oc);
      end
  endtask

  task automatic launch();
    exp_done++;
    @(posedge i_clk); #1 i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_done != 0 && n < budget) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("done_pending_at_timeout", exp_done, 0);
    exp_done = 0;
    @(posedge i_clk); #1;
  endtask

  task automatic drained(input string nm, input int iss0, input int wr0, input int n_iss, input int n_w);
    chk({nm, "_issue_count"}, n_issue - iss0, n_iss);
    chk({nm, "_write_count"}, n_wr - wr0, n_w);
    chk({nm, "_iss_queue_left"}, q_iss.size(), 0);
    chk({nm, "_wr_queue_left"}, q_wr.size(), 0);
    chk({nm, "_busy_after"}, o_busy, 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_issue"}, o_issue, 0);
    chk({nm, "_first_grp"}, o_first_grp, 0);
    chk({nm, "_wr_en"}, o_wr_en, 0);
    chk({nm, "_done"}, o_done, 0);
    chk({nm, "_raddrs"}, {o_raddr_0, o_raddr_1, o_raddr_2, o_raddr_3}, 0);
    chk({nm, "_raddr_wb"}, {o_raddr_weight, o_raddr_bias}, 0);
    chk({nm, "_waddr"}, o_waddr, 0);
    chk({nm, "_wr_ch"}, o_wr_ch, 0);
  endtask

  task automatic run_single();
    int i0, w0;
    i0 = n_issue; w0 = n_wr;
    set_cfg(0, 0, 0, 0, 8, 100, 5, 2);
    exp_iss(0, 0, 0, 0, 5, 2, 1, 1);
    exp_wr(0, 0);
    launch();
    wait_done(50);
    drained("single", i0, w0, 1, 1);
  endtask

  initial begin
    int i0, w0;
    i_rst = 1'b1; i_start = 1'b0; i_stall = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    chk_all_zero("reset");

    run_single();

    // Loop order
    i0 = n_issue; w0 = n_wr;
    set_cfg(1, 1, 1, 1, 8, 100, 10, 3);
    push_loop();
    launch();
    chk("loop_busy", o_busy, 1);
    wait_done(200);
    drained("loop", i0, w0, 16, 8);

    // Stall for 5 cycles while a write is already in the delay line
    i0 = n_issue; w0 = n_wr;
    set_cfg(1, 1, 1, 1, 8, 100, 10, 3);
    push_loop();
    launch();
    repeat (2) begin @(posedge i_clk); #1; end
    i_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk); #1;
      chk("stall_issue", o_issue, 0);
      chk("stall_raddrs", {o_raddr_0, o_raddr_1, o_raddr_2, o_raddr_3}, 0);
      chk("stall_weight", o_raddr_weight, 12);
      chk("stall_bias", o_raddr_bias, 4);
    end
    i_stall = 1'b0;
    wait_done(200);
    drained("stall", i0, w0, 16, 8);

    // Start while busy, with different config, must be ignored
    i0 = n_issue; w0 = n_wr;
    set_cfg(1, 1, 1, 1, 8, 100, 10, 3);
    push_loop();
    launch();
    repeat (3) begin @(posedge i_clk); #1; end
    set_cfg(0, 0, 0, 0, 1, 1, 99, 9);
    i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    wait_done(200);
    drained("busy_start", i0, w0, 16, 8);

    // Reset mid-layer with a write pending
    set_cfg(1, 1, 1, 1, 8, 100, 10, 3);
    push_loop();
    launch();
    repeat (2) begin @(posedge i_clk); #1; end
    i_rst = 1'b1;
    @(posedge i_clk); #1 i_rst = 1'b0;
    q_iss.delete(); q_wr.delete(); q_due.delete();
    exp_done = 0;
    chk_all_zero("mid_reset");
    w0 = n_wr;
    repeat (8) begin @(posedge i_clk); #1; end
    chk("mid_reset_no_wr", n_wr - w0, 0);
    chk("mid_reset_idle", o_busy, 0);
    run_single();

    // Weight address wrap
    i0 = n_issue; w0 = n_wr;
    set_cfg(0, 0, 1, 0, 8, 100, 126, 7);
    exp_iss(0, 0, 0, 0, 126, 7, 1, 0);
    exp_iss(100, 100, 100, 100, 127, 7, 0, 1);
    exp_wr(0, 0);
    launch();
    wait_done(50);
    drained("wrap126", i0, w0, 2, 1);

    i0 = n_issue; w0 = n_wr;
    set_cfg(0, 0, 1, 0, 8, 100, 127, 7);
    exp_iss(0, 0, 0, 0, 127, 7, 1, 0);
    exp_iss(100, 100, 100, 100, 0, 7, 0, 1);
    exp_wr(0, 0);
    launch();
    wait_done(50);
    drained("wrap127", i0, w0, 2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_layer_sched.md
Name: conv_layer_sched

Overview:
Layer sequencer for the 3x3 convolution datapath. On start it walks one layer's output tiles, output channels and input channel groups, in that nesting order. For each step it drives the read addresses of the 4 parity-interleaved activation banks and the weight and bias SRAM addresses. After the pipeline latency it raises a write strobe with the output address and channel. It sits between the top-level layer FSM and the conv datapath/SRAM ports.

Parameters:
ADDR_W, 14, activation SRAM address width
W_ADDR_W, 7, weight SRAM address width
B_ADDR_W, 5, bias SRAM address width
DIM_W, 7, width of tile-count config fields
LAT, 3, cycles from last-group issue to wr_en (SRAM read + MAC pipeline)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle layer start pulse
cfg_tile_w_m1  in  DIM_W  output tiles per row minus 1
cfg_tile_h_m1  in  DIM_W  output tile rows minus 1
cfg_in_grp_m1  in  4  input channel groups (CH_NUM ch each) minus 1
cfg_out_ch_m1  in  5  output channels minus 1
cfg_bank_stride  in  ADDR_W  bank address increment per bank row
cfg_grp_stride  in  ADDR_W  bank address offset per input group
cfg_w_base  in  W_ADDR_W  weight base address
cfg_b_base  in  B_ADDR_W  bias base address
stall  in  1  datapath back-pressure; freezes issue
busy  out  1  layer in progress
issue  out  1  read request valid this cycle
first_grp  out  1  issue is group 0 (datapath clears accumulator)
raddr_0..raddr_3  out  ADDR_W each  activation bank read addresses, bank b = {r,c}
raddr_weight  out  W_ADDR_W  weight read address
raddr_bias  out  B_ADDR_W  bias read address
wr_en  out  1  output write strobe
waddr  out  ADDR_W  output tile address
wr_ch  out  5  output channel of the write
done  out  1  one-cycle pulse after the final write

Behaviour:
- Reset (sync, rst=1): state IDLE. All counters 0, delay line cleared. busy, issue, first_grp, wr_en, done = 0. All address outputs = 0. Reset mid-layer aborts at once, and pending writes are discarded.
- States: IDLE -> RUN on start. RUN -> DRAIN when the final step issues. DRAIN -> IDLE when the delay line is empty; done pulses that same cycle. start is ignored unless in IDLE.
- Config is captured into registers on the accepted start. Later changes have no effect until the next start.
- Counters in RUN, innermost first:
  - ig 0..cfg_in_grp_m1
  - oc 0..cfg_out_ch_m1
  - tx 0..cfg_tile_w_m1
  - ty 0..cfg_tile_h_m1
  Each counter wraps to 0 and carries into the next outer one.
- issue = 1 every RUN cycle with stall=0. With stall=1: issue=0, counters and addresses hold. The delay line keeps advancing during stall.
- Addresses are registered and valid in the same cycle as issue:
  - bank {r,c}: raddr = ((ty + (r^ty[0]))>>1)*cfg_bank_stride + ((tx + (c^tx[0]))>>1) + ig*cfg_grp_stride
  - Multiplies may be replaced by running accumulators; results must match exactly, truncated to ADDR_W.
  - raddr_weight = cfg_w_base + oc*(cfg_in_grp_m1+1) + ig, mod 2^W_ADDR_W.
  - raddr_bias = cfg_b_base + oc, mod 2^B_ADDR_W.
- first_grp = issue & (ig==0).
- On an issue with ig==cfg_in_grp_m1, push {tile=ty*(cfg_tile_w_m1+1)+tx, oc} into a LAT-deep shift register. wr_en, waddr and wr_ch appear exactly LAT cycles later.
- Between writes, waddr and wr_ch hold their last value.
- Total issues = (W)(H)(G)(O), where each count is its cfg_*_m1 field +1. Writes = (W)(H)(O).
- Degenerate case, all *_m1 = 0: one issue with first_grp=1. wr_en follows LAT cycles later, and done one cycle after that.

Test Plan:
- Single step: all m1=0, w_base=5, b_base=2, start -> one issue, raddr_0..3 = 0, raddr_weight=5, raddr_bias=2. Then wr_en at issue+3 with waddr=0, wr_ch=0, and done at issue+4.
- Loop order: tile_w_m1=1, tile_h_m1=1, in_grp_m1=1, out_ch_m1=1, bank_stride=8, grp_stride=100 -> 16 issues.
  - ig toggles fastest and first_grp on every second issue.
  - At tx=1, ty=0, ig=1: raddr_0=101, raddr_1=100, raddr_2=101, raddr_3=100.
  - 8 writes in order with waddr 0,0,1,1,2,2,3,3 and wr_ch 0,1,0,1,...
- Stall: assert stall for 5 cycles mid-layer -> issue=0, addresses frozen. An already-pushed write still fires on time. Total issue count unchanged.
- Start while busy: pulse start with different cfg during RUN -> ignored, original sequence completes and a single done pulses.
- Reset mid-layer: rst during RUN with a write pending in the delay line -> next cycle all outputs 0, no wr_en, no done. A new start runs cleanly.
- Wrap: w_base=126, in_grp_m1=1, out_ch_m1=0 -> raddr_weight 126 then 127. With w_base=127: 127 then 0.
